serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Bit-serial sequencer for the team's registered 1-bit full-adder cell (`adder`). It accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake. It streams the operands LSB-first through one cell instance, feeding the registered carry back each cycle, then reassembles the WIDTH-bit sum and carry-out and presents them on a valid/ready output. It sits between an operand producer and a result consumer and keeps the area cost to a single 1-bit adder cell.

Parameters:
- WIDTH, 8: operand and sum width in bits; legal range 1..32.
- CW, derived as clog2(WIDTH)+1: bit counter width; local, not overridable.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset; also drives the cell's rst.
- in_valid, input, 1: operand request.
- in_ready, output, 1: controller can accept; high only in IDLE.
- a, input, WIDTH: operand A; sampled on in_valid & in_ready.
- b, input, WIDTH: operand B; sampled with a.
- cin, input, 1: carry-in; sampled with a.
- out_valid, output, 1: result available; high only in DONE.
- out_ready, input, 1: consumer accepts the result.
- sum, output, WIDTH: result bits; stable while out_valid.
- cout, output, 1: final carry-out; stable while out_valid.
- busy, output, 1: high in RUN, DRAIN and DONE.

Behaviour:
- Reset (rst=1 at a clk edge): state goes to IDLE; bit counter, operand, sum and cout registers clear to 0; in_ready=1, out_valid=0, busy=0, sum=0, cout=0. Reset mid-operation aborts the operation with no partial result output. The cell is cleared by the same rst.
- IDLE: in_ready=1. On in_valid=1:
  - latch a, b and cin;
  - clear the counter;
  - go to RUN.
  - in_valid=0 keeps the state in IDLE.
- RUN, exactly WIDTH cycles, counter k = 0..WIDTH-1:
  - Cell A input = a_reg[0]; cell B input = b_reg[0].
  - Cell cin = latched cin when k==0, else the cell's registered carry output.
  - a_reg and b_reg shift right by 1 each cycle.
  - From k>=1, the cell sum output (bit k-1) shifts into sum_reg MSB-first, right-shift, so bit 0 ends in LSB.
  - At k==WIDTH-1, go to DRAIN.
- DRAIN, 1 cycle:
  - capture the last cell sum bit (bit WIDTH-1) into sum_reg;
  - capture the cell carry into cout;
  - go to DONE.
  - Cell inputs are don't-care here; drive them 0.
- DONE: out_valid=1 and sum/cout held constant.
  - out_ready=1 → IDLE at that edge.
  - out_ready=0 → stay in DONE indefinitely with outputs unchanged.
- Latency: the acceptance edge is E0. out_valid is first high in the cycle after edge E(WIDTH+1).
- Throughput: one operation per WIDTH+3 cycles minimum. There is no overlap; in_ready is not re-asserted in the same cycle as output acceptance.
- in_valid while busy is ignored; a, b and cin are not sampled.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). No signedness.
- WIDTH=1: RUN lasts one cycle, then DRAIN, then DONE.
- Idle cell inputs are held at 0.

Decomposition:
- Shared header/package serial_add_pkg:
  - state encodings: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3;
  - default WIDTH constant.
- One sub-module: the existing `adder` cell, instantiated once (u_fa). No other hierarchy.
- Datapath shift registers and the FSM stay in serial_add_ctrl.

Test Plan:
- WIDTH=8; a=0x5A, b=0x3C, cin=0; out_ready=1 → out_valid is first high 9 cycles after the acceptance edge, with sum=0x96, cout=0; the next cycle in_ready=1.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1 (full carry ripple across all bits).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_valid, sum and cout stay constant and in_ready=0. Raising out_ready completes the handshake, then the FSM returns to IDLE.
- Assert in_valid with a=0x11, b=0x22 during RUN → the values are ignored and the current result is unaffected. Reset asserted in RUN cycle k=3 → the next cycle shows in_ready=1, out_valid=0, sum=0, cout=0; a fresh op of 0x01+0x01 then gives 0x02.
- Random sweep of 1000 ops with random in_valid/out_ready gaps, compared against the a+b+cin model. Also run WIDTH=1, all 8 input combos → result equals the full-adder truth table with latency 2 cycles.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder controller: FSM state
// encodings and the default operand width.
package serial_add_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle between a producer/consumer (master)
// and the bit-serial adder controller (slave).
interface serial_add_ctrl_if #(
  parameter int WIDTH = serial_add_pkg::WIDTH_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/adder.sv
// Registered 1-bit full-adder cell: sum and carry appear one clock after
// the inputs are presented.
module adder (
  input  logic clk,
  input  logic rst,
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  logic sum_q;
  logic cout_q;

  // Register the full-adder result; cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= a_i ^ b_i ^ cin_i;
      cout_q <= (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: accepts two WIDTH-bit operands plus carry-in,
// streams them LSB-first through a single registered full-adder cell with
// the carry fed back, and reassembles {cout, sum} for a valid/ready consumer.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_ctrl_if.slave bus
);

  localparam int             CW     = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  K_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_a, fa_b, fa_cin;
  logic fa_sum, fa_cout;

  // Right-shift the result register, inserting the newest bit at the MSB so
  // that after WIDTH insertions bit 0 of the sum sits in the LSB.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v,
                                                input logic             bit_in);
    logic [WIDTH-1:0] r;
    r            = v >> 1;
    r[WIDTH-1]   = bit_in;
    return r;
  endfunction

  adder u_fa (
    .clk    (clk),
    .rst    (rst),
    .a_i    (fa_a),
    .b_i    (fa_b),
    .cin_i  (fa_cin),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  // Next-state and datapath steering; the cell sees zeros outside RUN.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    fa_a    = 1'b0;
    fa_b    = 1'b0;
    fa_cin  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          cin_d   = bus.cin;
          k_d     = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        fa_a   = a_q[0];
        fa_b   = b_q[0];
        // First bit uses the operand carry-in, later bits the cell's own carry.
        fa_cin = (k_q == '0) ? cin_q : fa_cout;
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        // The cell output lags by one cycle, so bit k-1 is ready at step k.
        if (k_q != '0) begin
          sum_d = shift_in(sum_q, fa_sum);
        end
        k_d = k_q + CW'(1);
        if (k_q == K_LAST) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        sum_d   = shift_in(sum_q, fa_sum);
        cout_d  = fa_cout;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: table-driven vectors, latency,
// backpressure, ignored input while busy, mid-run reset, a random sweep
// against an a+b+cin model, and the WIDTH=1 full-adder truth table.
module tb_serial_add_ctrl;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic rnd_rdy   = 1'b0;
  logic rdy_fixed = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] sb_q[$];
  vec_t       vecs[8];
  logic [1:0] fa_exp[8];

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8)) bus ();
  serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sole driver of out_ready: fixed level or random, changed just after posedge.
  always @(posedge clk) begin
    #1;
    bus.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // Scoreboard: compare each accepted result with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got %0h with empty scoreboard", {bus.cout, bus.sum});
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        chk("result", 32'({bus.cout, bus.sum}), 32'(e));
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [8:0] exp, input bit push);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
    if (push) sb_q.push_back(exp);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts negedges after the acceptance edge until out_valid shows.
  task automatic wait_valid(output int n);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_seen", 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    logic [7:0] ra, rb;
    logic       rc;
    logic [2:0] iv;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[2] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    fa_exp  = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.cin        = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.a         = '0;
    bus1.b         = '0;
    bus1.cin       = 1'b0;
    bus1.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_sum",       32'(bus.sum),       32'd0);
    chk("rst_cout",      32'(bus.cout),      32'd0);

    // Latency: first out_valid 9 cycles after acceptance, then back to IDLE.
    send(8'h5A, 8'h3C, 1'b0, 9'h096, 1'b1);
    n = 0;
    @(negedge clk);
    chk("run_busy",     32'(bus.busy),     32'd1);
    chk("run_in_ready", 32'(bus.in_ready), 32'd0);
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("latency_w8", 32'(n), 32'd9);
    @(negedge clk);
    chk("ready_after_accept", 32'(bus.in_ready),  32'd1);
    chk("valid_after_accept", 32'(bus.out_valid), 32'd0);

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum}, 1'b1);
      wait_valid(n);
      chk("latency_vec", 32'(n + 1), 32'd10);
      @(posedge clk);
      #1;
    end

    // Backpressure: result held steady while the consumer stalls.
    rdy_fixed = 1'b0;
    @(posedge clk);
    #1;
    send(8'h12, 8'h34, 1'b1, 9'h047, 1'b1);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      chk("bp_sum",       32'(bus.sum),       32'h47);
      chk("bp_cout",      32'(bus.cout),      32'd0);
      @(negedge clk);
    end
    rdy_fixed = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);

    // New request while busy must be ignored.
    send(8'h0F, 8'h01, 1'b0, 9'h010, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 8'h11;
    bus.b        = 8'h22;
    bus.cin      = 1'b1;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("busy_ignore_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    chk("no_spurious_op", 32'(cnt), 32'd0);
    chk("sb_empty_after_ignore", 32'(sb_q.size()), 32'd0);

    // Reset during RUN cycle k=3 aborts with no output.
    send(8'h33, 8'h44, 1'b0, 9'h077, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_sum",       32'(bus.sum),       32'd0);
    chk("midrst_cout",      32'(bus.cout),      32'd0);
    chk("midrst_busy",      32'(bus.busy),      32'd0);
    send(8'h01, 8'h01, 1'b0, 9'h002, 1'b1);
    wait_valid(n);
    @(posedge clk);
    #1;

    // Random sweep with random gaps and random consumer stalls.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      send(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc}, 1'b1);
    end
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("sweep_drained", 32'(sb_q.size()), 32'd0);
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2;

    // WIDTH=1 instance: full-adder truth table, 2-cycle latency.
    for (int i = 0; i < 8; i++) begin
      iv = 3'(i);
      @(negedge clk);
      n = 0;
      while (!bus1.in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      bus1.in_valid = 1'b1;
      bus1.a        = iv[2];
      bus1.b        = iv[1];
      bus1.cin      = iv[0];
      @(posedge clk);
      #1 bus1.in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!bus1.out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("w1_latency", 32'(n), 32'd2);
      chk("w1_result", 32'({bus1.cout, bus1.sum}), 32'(fa_exp[i]));
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
